time_entry: RTL and testbench
=============================

Name: time_entry

Overview:
- Keypad-side writer for the microwave countdown timer chain. Collects up to four BCD digits typed on the keypad (MM:SS, shifted in right-to-left like a calculator display) and validates them on START.
- Drives the parallel-load interface of the four decimal timer digits: data nibbles, active-low load strobe, and load enable.
- Tracks RUN until the timer chain reports done, or until CLEAR aborts the run.

Parameters:
- KEY_CLEAR, 4'hA, key code that clears the entry or aborts a run
- KEY_START, 4'hB, key code that validates and loads the entry
- SEC_TENS_MAX, 5, largest legal seconds-tens digit

Ports:
- clk  input  1  system clock, rising edge
- clrn  input  1  asynchronous active-low reset
- key_valid  input  1  one-cycle strobe; key_code is valid when high
- key_code  input  4  0-9 digit; KEY_CLEAR; KEY_START; other codes are ignored
- timer_done  input  1  high when the timer chain has counted to 00:00
- d_min_tens  output  4  BCD load data / display, minutes tens
- d_min_ones  output  4  BCD load data / display, minutes ones
- d_sec_tens  output  4  BCD load data / display, seconds tens
- d_sec_ones  output  4  BCD load data / display, seconds ones
- loadn  output  1  active-low parallel load to the timer digits
- load_en  output  1  enable to the timer digits during load
- run  output  1  high while the timer is counting
- err  output  1  one-cycle pulse on a rejected START
- aborted  output  1  one-cycle pulse when CLEAR is pressed during RUN

Behaviour:
- Reset (clrn low, asynchronous): state IDLE, all digit registers 0, digit count 0, loadn=1, load_en=0, run=0, err=0, aborted=0. Reset mid-LOAD or mid-RUN behaves identically.
- All registers update on the clk rising edge. Keys are acted on only in the cycle key_valid=1.
- States: IDLE, ENTRY, LOAD, RUN.
- IDLE
  - Digit key: d_sec_ones <= key, count <= 1, go to ENTRY.
  - CLEAR and START: ignored.
- ENTRY
  - Digit key with count<4: shift min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key; count++.
  - Digit key with count==4: ignored, digits unchanged.
  - CLEAR: all digits 0, count 0, go to IDLE.
  - START with all digits zero: ignored, stay in ENTRY.
  - START with d_sec_tens>SEC_TENS_MAX: err=1 for one cycle, stay in ENTRY (see Optional Feature).
  - START otherwise: go to LOAD.
- LOAD (exactly one cycle)
  - loadn=0 and load_en=1 while in this state. The timer samples the data at the edge that ends LOAD.
  - Next state is RUN.
  - Digits are frozen from the START edge until LOAD ends.
- RUN
  - run=1. Digit and START keys are ignored.
  - CLEAR: aborted=1 for one cycle, digits 0, count 0, go to IDLE.
  - timer_done=1: go to IDLE, digits 0, count 0.
  - CLEAR and timer_done in the same cycle: CLEAR wins, so aborted pulses.
  - timer_done is ignored in every state except RUN.
- loadn, load_en, run, err and aborted are all registered (decoded from registered state/flags), so no combinational path runs from key inputs to outputs.
- Latency: START sampled at edge N; loadn low from N to N+1; run high from N+1 until exit.

Optional Feature:
- Macro: TIME_ENTRY_NORMALIZE_EN.
- Defined: a START with sec_tens>SEC_TENS_MAX is normalized in the START cycle instead of rejected.
  - sec_tens <= sec_tens-6; minutes +1 in BCD (min_ones 9 wraps to 0 and carries into min_tens).
  - Example: 00:90 becomes 01:30.
  - If minutes are already 99: err pulse, no load.
  - Otherwise proceed to LOAD with the normalized digits.
- Not defined: the err behaviour described above.

Decomposition:
- Shared header microwave_defs.vh: key codes (KEY_CLEAR, KEY_START), state encodings (2-bit: IDLE=0, ENTRY=1, LOAD=2, RUN=3), SEC_TENS_MAX.
- One sub-module, time_entry_shreg:
  - 4x4-bit digit shift register with count, shift, clear and normalize controls.
  - The FSM stays in time_entry.

Test Plan:
- Reset, then keys 1,2,3,0,START → digits 12:30; loadn low exactly one cycle, 1 cycle after START; run=1 the following cycle.
- Keys 1,2,3,4,5 → digits 12:34 (5th key ignored); CLEAR → 00:00, IDLE, no loadn.
- Keys 9,0,START → without macro: err pulse, stays in ENTRY, loadn stays 1. With macro: loads 01:30.
- START from IDLE and START on 00:00 in ENTRY → no load, no err.
- In RUN, assert CLEAR and timer_done in the same cycle → aborted pulse, IDLE, run=0. Separately, timer_done alone → IDLE, no aborted.
- Assert clrn low while in LOAD → loadn=1, run=0, digits 0 immediately, with no clock required.

Source files
------------

// File: rtl/time_entry_pkg.sv
// ---------------------------------------------------------------------------
// time_entry_pkg
// Shared definitions for the microwave keypad time-entry block: key codes,
// FSM state encoding, the largest legal seconds-tens digit and a small
// key-classification helper.
// Imported by time_entry_if, time_entry_shreg and time_entry.
// ---------------------------------------------------------------------------
package time_entry_pkg;

    localparam logic [3:0] KEY_CLEAR    = 4'hA;
    localparam logic [3:0] KEY_START    = 4'hB;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Two-bit encoding shared with the rest of the timer chain.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Key codes 0..9 are decimal digits; everything else is a command or junk.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/time_entry_if.sv
// ---------------------------------------------------------------------------
// time_entry_if
// Bundles the keypad strobe, the timer-chain status and the parallel-load
// bus that time_entry drives into the four decimal timer digits.
//   key_valid, key_code    keypad strobe and code
//   timer_done             timer chain has reached 00:00
//   d_min_tens..d_sec_ones BCD load data / display digits
//   loadn, load_en         parallel load strobe (active low) and enable
//   run, err, aborted      status: counting, rejected START, CLEAR during run
// modport master : the time_entry side (drives the load bus and status)
// modport slave  : the keypad / timer-chain side
// ---------------------------------------------------------------------------
interface time_entry_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_done;
    logic [3:0] d_min_tens;
    logic [3:0] d_min_ones;
    logic [3:0] d_sec_tens;
    logic [3:0] d_sec_ones;
    logic       loadn;
    logic       load_en;
    logic       run;
    logic       err;
    logic       aborted;

    modport master (
        input  key_valid, key_code, timer_done,
        output d_min_tens, d_min_ones, d_sec_tens, d_sec_ones,
        output loadn, load_en, run, err, aborted
    );

    modport slave (
        output key_valid, key_code, timer_done,
        input  d_min_tens, d_min_ones, d_sec_tens, d_sec_ones,
        input  loadn, load_en, run, err, aborted
    );

endinterface

// File: rtl/time_entry_shreg.sv
// ---------------------------------------------------------------------------
// time_entry_shreg
// Four-digit BCD shift register holding the MM:SS entry plus the count of
// digits typed so far. New digits enter at seconds-ones and push the older
// digits left, like a calculator display.
//   clk, clrn   clock and asynchronous active-low reset
//   shift       shift key into sec_ones, count+1
//   clear       zero all digits and the count
//   norm        turn SS>=60 into +1 minute (sec_tens-6, BCD carry into minutes)
//   key         digit to shift in
//   min_tens..sec_ones, count   register contents
// Priority is clear > norm > shift; the FSM never asserts more than one.
// ---------------------------------------------------------------------------
module time_entry_shreg
    import time_entry_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       shift,
    input  logic       clear,
    input  logic       norm,
    input  logic [3:0] key,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] count
);

    // Digit storage. The caller guarantees minutes are not 99 when norm is
    // asserted, so the carry out of min_tens never has to be handled here.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            count    <= 3'd0;
        end else if (clear) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            count    <= 3'd0;
        end else if (norm) begin
            sec_tens <= sec_tens - 4'd6;
            if (min_ones == 4'd9) begin
                min_ones <= 4'd0;
                min_tens <= min_tens + 4'd1;
            end else begin
                min_ones <= min_ones + 4'd1;
            end
        end else if (shift) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= key;
            count    <= count + 3'd1;
        end
    end

endmodule

// File: rtl/time_entry.sv
// ---------------------------------------------------------------------------
// time_entry
// Keypad-side writer for the microwave countdown timer. Collects up to four
// BCD digits (MM:SS), validates them on START, issues a one-cycle parallel
// load into the timer digits, then tracks RUN until timer_done or CLEAR.
//   clk   system clock, rising edge
//   clrn  asynchronous active-low reset
//   bus   time_entry_if.master: keypad in, timer_done in, load bus and
//         status (run, err, aborted) out
// Build option: define TIME_ENTRY_NORMALIZE_EN to turn a START with seconds
// tens above 5 into a minute carry (00:90 -> 01:30) instead of an err pulse.
// All outputs come from registers, so keys never reach outputs combinationally.
// ---------------------------------------------------------------------------
module time_entry
    import time_entry_pkg::*;
(
    input  logic          clk,
    input  logic          clrn,
    time_entry_if.master  bus
);

    state_t     state, state_nx;
    logic       err_q, err_nx;
    logic       abort_q, abort_nx;
    logic       shift, clear, norm;
    logic       key_dig, key_clr, key_start;
    logic       all_zero;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] count;

    assign key_dig   = bus.key_valid && is_digit(bus.key_code);
    assign key_clr   = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign key_start = bus.key_valid && (bus.key_code == KEY_START);
    assign all_zero  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);

    time_entry_shreg u_shreg (
        .clk      (clk),
        .clrn     (clrn),
        .shift    (shift),
        .clear    (clear),
        .norm     (norm),
        .key      (bus.key_code),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .count    (count)
    );

    // State register plus the two one-cycle status pulses.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nx;
            err_q   <= err_nx;
            abort_q <= abort_nx;
        end
    end

    // Next-state and shift-register control. Digits are always zero in IDLE,
    // so the first digit can use the ordinary shift to land in sec_ones.
    // In RUN, CLEAR is tested before timer_done so a simultaneous press aborts.
    always_comb begin
        state_nx = state;
        shift    = 1'b0;
        clear    = 1'b0;
        norm     = 1'b0;
        err_nx   = 1'b0;
        abort_nx = 1'b0;
        case (state)
            IDLE: begin
                if (key_dig) begin
                    shift    = 1'b1;
                    state_nx = ENTRY;
                end
            end
            ENTRY: begin
                if (key_dig) begin
                    shift = (count < 3'd4);
                end else if (key_clr) begin
                    clear    = 1'b1;
                    state_nx = IDLE;
                end else if (key_start && !all_zero) begin
                    if (sec_tens > SEC_TENS_MAX) begin
`ifdef TIME_ENTRY_NORMALIZE_EN
                        if (min_tens == 4'd9 && min_ones == 4'd9) begin
                            err_nx = 1'b1;
                        end else begin
                            norm     = 1'b1;
                            state_nx = LOAD;
                        end
`else
                        err_nx = 1'b1;
`endif
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                state_nx = RUN;
            end
            RUN: begin
                if (key_clr) begin
                    abort_nx = 1'b1;
                    clear    = 1'b1;
                    state_nx = IDLE;
                end else if (bus.timer_done) begin
                    clear    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.d_min_tens = min_tens;
    assign bus.d_min_ones = min_ones;
    assign bus.d_sec_tens = sec_tens;
    assign bus.d_sec_ones = sec_ones;
    assign bus.loadn      = (state != LOAD);
    assign bus.load_en    = (state == LOAD);
    assign bus.run        = (state == RUN);
    assign bus.err        = err_q;
    assign bus.aborted    = abort_q;

endmodule

// File: tb/tb_time_entry.sv
// ---------------------------------------------------------------------------
// tb_time_entry
// Self-checking bench for time_entry. The reference model treats the entry
// as a plain decimal number MMSS and applies the keypad rules arithmetically.
// Honours TIME_ENTRY_NORMALIZE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_time_entry;
    import time_entry_pkg::*;

    logic clk = 1'b0;
    logic clrn;
    int   checks = 0;
    int   errors = 0;

    // Reference model: entry value as a number 0..9999, digits typed,
    // phase 0=waiting 1=typing 2=loading 3=counting, and pulse expectations.
    int   m_value;
    int   m_count;
    int   m_phase;
    bit   m_err;
    bit   m_abort;

    always #5 clk = ~clk;

    time_entry_if bus ();

    time_entry dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_value = 0;
        m_count = 0;
        m_phase = 0;
        m_err   = 1'b0;
        m_abort = 1'b0;
    endtask

    // One clock edge of the keypad rules applied to the decimal entry.
    task automatic modelStep(input logic v, input logic [3:0] c, input logic d);
        int mins, secs;
        m_err   = 1'b0;
        m_abort = 1'b0;
        mins    = m_value / 100;
        secs    = m_value % 100;
        case (m_phase)
            0: begin
                if (v && c <= 4'd9) begin
                    m_value = int'(c);
                    m_count = 1;
                    m_phase = 1;
                end
            end
            1: begin
                if (v && c <= 4'd9) begin
                    if (m_count < 4) begin
                        m_value = (m_value * 10 + int'(c)) % 10000;
                        m_count++;
                    end
                end else if (v && c == KEY_CLEAR) begin
                    m_value = 0;
                    m_count = 0;
                    m_phase = 0;
                end else if (v && c == KEY_START && m_value != 0) begin
                    if (secs / 10 > 5) begin
`ifdef TIME_ENTRY_NORMALIZE_EN
                        if (mins == 99) m_err = 1'b1;
                        else begin
                            m_value = (mins + 1) * 100 + (secs - 60);
                            m_phase = 2;
                        end
`else
                        m_err = 1'b1;
`endif
                    end else begin
                        m_phase = 2;
                    end
                end
            end
            2: m_phase = 3;
            default: begin
                if (v && c == KEY_CLEAR) begin
                    m_abort = 1'b1;
                    m_value = 0;
                    m_count = 0;
                    m_phase = 0;
                end else if (d) begin
                    m_value = 0;
                    m_count = 0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic checkAll(input string tag);
        logic [15:0] exp_digits;
        exp_digits = {4'((m_value / 1000) % 10), 4'((m_value / 100) % 10),
                      4'((m_value / 10) % 10), 4'(m_value % 10)};
        checkOutput({tag, ".digits"},
                    {16'h0, bus.d_min_tens, bus.d_min_ones, bus.d_sec_tens, bus.d_sec_ones},
                    {16'h0, exp_digits});
        checkOutput({tag, ".loadn"},   32'(bus.loadn),   32'(m_phase != 2));
        checkOutput({tag, ".load_en"}, 32'(bus.load_en), 32'(m_phase == 2));
        checkOutput({tag, ".run"},     32'(bus.run),     32'(m_phase == 3));
        checkOutput({tag, ".err"},     32'(bus.err),     32'(m_err));
        checkOutput({tag, ".aborted"}, 32'(bus.aborted), 32'(m_abort));
    endtask

    // Called at a falling edge: drive for one rising edge, then check.
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [3:0] c, input logic d);
        bus.key_valid  = v;
        bus.key_code   = c;
        bus.timer_done = d;
        @(negedge clk);
        bus.key_valid  = 1'b0;
        bus.timer_done = 1'b0;
        modelStep(v, c, d);
        checkAll(tag);
    endtask

    task automatic pressKey(input string tag, input logic [3:0] c);
        applyStimulus(tag, 1'b1, c, 1'b0);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        int r;
        logic [3:0] code;
        clrn           = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.timer_done = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll("reset");
        clrn = 1'b1;

        // 1,2,3,0,START -> 12:30 loaded for exactly one cycle, then run
        pressKey("k1", 4'd1);
        pressKey("k2", 4'd2);
        pressKey("k3", 4'd3);
        pressKey("k0", 4'd0);
        pressKey("start1230", KEY_START);
        checkOutput("load1230.digits",
                    {16'h0, bus.d_min_tens, bus.d_min_ones, bus.d_sec_tens, bus.d_sec_ones},
                    32'h1230);
        checkOutput("load1230.loadn", 32'(bus.loadn), 32'd0);
        idleCycle("run1230");
        checkOutput("run1230.run", 32'(bus.run), 32'd1);
        checkOutput("run1230.loadn", 32'(bus.loadn), 32'd1);
        applyStimulus("done1230", 1'b0, 4'h0, 1'b1);

        // Fifth digit ignored, then CLEAR
        pressKey("e1", 4'd1);
        pressKey("e2", 4'd2);
        pressKey("e3", 4'd3);
        pressKey("e4", 4'd4);
        pressKey("e5", 4'd5);
        checkOutput("full1234.digits",
                    {16'h0, bus.d_min_tens, bus.d_min_ones, bus.d_sec_tens, bus.d_sec_ones},
                    32'h1234);
        applyStimulus("entry_done_ignored", 1'b0, 4'h0, 1'b1);
        pressKey("clear1234", KEY_CLEAR);

        // 9,0,START: rejected or normalized depending on the build
        pressKey("n9", 4'd9);
        pressKey("n0", 4'd0);
        pressKey("start90", KEY_START);
`ifdef TIME_ENTRY_NORMALIZE_EN
        checkOutput("norm90.digits",
                    {16'h0, bus.d_min_tens, bus.d_min_ones, bus.d_sec_tens, bus.d_sec_ones},
                    32'h0130);
        checkOutput("norm90.loadn", 32'(bus.loadn), 32'd0);
        idleCycle("norm90.run");
        applyStimulus("norm90.done", 1'b0, 4'h0, 1'b1);
`else
        checkOutput("rej90.err", 32'(bus.err), 32'd1);
        checkOutput("rej90.loadn", 32'(bus.loadn), 32'd1);
        idleCycle("rej90.after");
        checkOutput("rej90.err_gone", 32'(bus.err), 32'd0);
        pressKey("rej90.clear", KEY_CLEAR);
`endif

        // 99:60 cannot normalize either way
        pressKey("m9a", 4'd9);
        pressKey("m9b", 4'd9);
        pressKey("m6", 4'd6);
        pressKey("m0", 4'd0);
        pressKey("start9960", KEY_START);
        checkOutput("start9960.err", 32'(bus.err), 32'd1);
        pressKey("clear9960", KEY_CLEAR);

        // START from IDLE and START on 00:00
        pressKey("start_idle", KEY_START);
        pressKey("z0", 4'd0);
        pressKey("start_zero", KEY_START);
        checkOutput("start_zero.loadn", 32'(bus.loadn), 32'd1);
        checkOutput("start_zero.err", 32'(bus.err), 32'd0);
        pressKey("junk", 4'hE);
        pressKey("clear_zero", KEY_CLEAR);

        // CLEAR and timer_done together in RUN -> abort
        pressKey("a5", 4'd5);
        pressKey("start5", KEY_START);
        idleCycle("run5");
        pressKey("run5.digit_ignored", 4'd7);
        pressKey("run5.start_ignored", KEY_START);
        applyStimulus("abort5", 1'b1, KEY_CLEAR, 1'b1);
        checkOutput("abort5.aborted", 32'(bus.aborted), 32'd1);
        checkOutput("abort5.run", 32'(bus.run), 32'd0);
        idleCycle("abort5.after");

        // timer_done alone -> IDLE without abort
        pressKey("b7", 4'd7);
        pressKey("start7", KEY_START);
        idleCycle("run7");
        applyStimulus("done7", 1'b0, 4'h0, 1'b1);
        checkOutput("done7.aborted", 32'(bus.aborted), 32'd0);

        // Asynchronous reset while in LOAD
        pressKey("c4", 4'd4);
        pressKey("start4", KEY_START);
        #2 clrn = 1'b0;
        #1;
        modelReset();
        checkOutput("rstload.loadn", 32'(bus.loadn), 32'd1);
        checkOutput("rstload.run", 32'(bus.run), 32'd0);
        checkOutput("rstload.digits",
                    {16'h0, bus.d_min_tens, bus.d_min_ones, bus.d_sec_tens, bus.d_sec_ones},
                    32'h0);
        @(negedge clk);
        checkAll("rstload.held");
        clrn = 1'b1;

        // Randomized keypad traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       code = 4'($urandom_range(0, 9));
            else if (r == 6) code = KEY_CLEAR;
            else if (r == 7) code = KEY_START;
            else if (r == 8) code = 4'($urandom_range(12, 15));
            else             code = 4'($urandom_range(6, 9));
            applyStimulus("rand", 1'($urandom_range(0, 1)), code,
                          ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
